// File: rtl/vga_rx_pkg.sv
// Shared types and default 640x480@60 timing for the VGA receive path.
// CRC constants are used only when VGA_RX_CRC_EN is defined.
package vga_rx_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } rx_state_t;

  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_H_START  = 144;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_TOTAL  = 525;
  localparam int DEF_V_START  = 35;
  localparam int DEF_V_ACTIVE = 480;
  localparam bit DEF_SYNC_POL = 1'b0;

  localparam logic [10:0] HCNT_MAX = 11'h7ff;
  localparam logic [9:0]  VCNT_MAX = 10'h3ff;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hffff;

endpackage

// File: rtl/vga_rx_crc16.sv
// One CRC-16-CCITT step over a 9-bit pixel, MSB first.
module vga_rx_crc16
  import vga_rx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [8:0]  data,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 8; i >= 0; i--) begin
      crc_out = {crc_out[14:0], 1'b0}
              ^ ((crc_out[15] ^ data[i]) ? CRC_POLY : 16'h0);
    end
  end

endmodule

// File: rtl/vga_rx_decoder.sv
// VGA receive decoder: sync recovery, mode lock, pixel x/y/rgb stream.
// Define VGA_RX_CRC_EN to add a per-frame CRC-16 over valid pixels.
module vga_rx_decoder
  import vga_rx_pkg::*;
#(
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int H_START  = DEF_H_START,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int V_START  = DEF_V_START,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic [2:0]  r,
  input  logic [2:0]  g,
  input  logic [2:0]  b,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [8:0]  pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        err,
  output logic [15:0] frame_crc,
  output logic        crc_valid
);

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_LO   = 11'(H_START);
  localparam logic [10:0] H_HI   = 11'(H_START + H_ACTIVE);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_LO   = 10'(V_START);
  localparam logic [9:0]  V_HI   = 10'(V_START + V_ACTIVE);

  logic        s1_hs, s1_vs, s2_hs, s2_vs;
  logic [8:0]  s1_rgb;
  logic [10:0] hcnt, hcnt_nx;
  logic [9:0]  vcnt, vcnt_nx;
  logic        armed, bad, frame_en;
  rx_state_t   state;

  logic hs_lead, vs_lead, line0, h_ok, sat, v_bad, act;

  assign hs_lead = (s1_hs == SYNC_POL) && (s2_hs != SYNC_POL);
  assign vs_lead = (s1_vs == SYNC_POL) && (s2_vs != SYNC_POL);
  assign line0   = hs_lead && (armed || vs_lead);
  assign h_ok    = (hcnt == H_LAST);
  assign sat     = !hs_lead && (hcnt == HCNT_MAX - 11'd1);
  // short frame at line 0, or an extra line past the end
  assign v_bad   = line0 ? (vcnt != V_LAST) : (vcnt == V_LAST);

  always_comb begin
    hcnt_nx = hcnt;
    vcnt_nx = vcnt;
    if (hs_lead) hcnt_nx = '0;
    else if (hcnt != HCNT_MAX) hcnt_nx = hcnt + 11'd1;
    if (line0) vcnt_nx = '0;
    else if (hs_lead && vcnt != VCNT_MAX) vcnt_nx = vcnt + 10'd1;
  end

  // state only changes where hcnt_nx is outside the active window
  assign act = (state == LOCKED) && frame_en
            && (hcnt_nx >= H_LO) && (hcnt_nx < H_HI)
            && (vcnt_nx >= V_LO) && (vcnt_nx < V_HI);

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hs       <= ~SYNC_POL;
      s1_vs       <= ~SYNC_POL;
      s2_hs       <= ~SYNC_POL;
      s2_vs       <= ~SYNC_POL;
      s1_rgb      <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      armed       <= 1'b0;
      bad         <= 1'b0;
      frame_en    <= 1'b0;
      state       <= SEARCH;
      err         <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
    end else begin
      s1_hs  <= hs;
      s1_vs  <= vs;
      s1_rgb <= {r, g, b};
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      hcnt   <= hcnt_nx;
      vcnt   <= vcnt_nx;
      if (line0) armed <= 1'b0;
      else if (vs_lead) armed <= 1'b1;
      err         <= 1'b0;
      pix_valid   <= act;
      pix_x       <= act ? 10'(hcnt_nx - H_LO) : '0;
      pix_y       <= act ? (vcnt_nx - V_LO) : '0;
      pix_rgb     <= act ? s1_rgb : '0;
      frame_start <= act && (hcnt_nx == H_LO) && (vcnt_nx == V_LO);
      unique case (state)
        SEARCH: begin
          if (line0) begin
            state <= MEASURE;
            bad   <= 1'b0;
          end
        end
        MEASURE: begin
          if (sat) state <= SEARCH;
          else if (line0)
            state <= (!bad && h_ok && !v_bad) ? LOCKED : SEARCH;
          else if (hs_lead && !h_ok) bad <= 1'b1;
        end
        LOCKED: begin
          if (sat || (hs_lead && (!h_ok || v_bad))) begin
            err      <= 1'b1;
            state    <= SEARCH;
            frame_en <= 1'b0;
          end else if (line0) frame_en <= 1'b1;
        end
        default: state <= SEARCH;
      endcase
    end
  end

`ifdef VGA_RX_CRC_EN
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  logic [15:0] crc_acc, crc_nx;
  logic        crc_run, last_pix;

  assign last_pix = pix_valid && (pix_x == X_LAST) && (pix_y == Y_LAST);

  vga_rx_crc16 u_crc (
    .crc_in  (frame_start ? CRC_INIT : crc_acc),
    .data    (pix_rgb),
    .crc_out (crc_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_acc   <= '0;
      crc_run   <= 1'b0;
      frame_crc <= '0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      if (!locked) crc_run <= 1'b0;
      else if (pix_valid) begin
        crc_acc <= crc_nx;
        if (frame_start) crc_run <= 1'b1;
        if (last_pix && (crc_run || frame_start)) begin
          frame_crc <= crc_nx;
          crc_valid <= 1'b1;
          crc_run   <= 1'b0;
        end
      end
    end
  end
`else
  assign frame_crc = 16'h0;
  assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Bench for vga_rx_decoder on a reduced video mode with a frame-level
// source model; expected pixels come from the source raster position.
module tb_vga_rx_decoder;

  localparam int HT  = 24;
  localparam int HS  = 6;
  localparam int HA  = 12;
  localparam int VT  = 14;
  localparam int VS  = 3;
  localparam int VA  = 8;
  localparam int HSW = 3;
  localparam int VSW = 2;
  localparam bit POL = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs  = 1'b1;
  logic        vs  = 1'b1;
  logic [2:0]  r   = '0;
  logic [2:0]  g   = '0;
  logic [2:0]  b   = '0;
  logic        pix_valid, frame_start, locked, err, crc_valid;
  logic [9:0]  pix_x, pix_y;
  logic [8:0]  pix_rgb;
  logic [15:0] frame_crc;

  vga_rx_decoder #(
    .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA),
    .SYNC_POL(POL)
  ) dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs),
    .r(r), .g(g), .b(b),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb), .frame_start(frame_start),
    .locked(locked), .err(err),
    .frame_crc(frame_crc), .crc_valid(crc_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [30:0] exp_q[$];
  logic [30:0] obs_q[$];
  int chk_from = 0;
  int step_n = 0;
  int err_cnt = 0;
  int crcv_cnt = 0;
  int lock_rise_at = -1;
  logic lock_prev = 1'b0;
  logic [15:0] crc_last = '0;

  // obs_q[i] holds what the DUT shows for the sample in exp_q[i-2]
  task automatic step(input logic rs, input logic h, input logic v,
                      input logic [8:0] rgb, input logic [30:0] e);
    @(negedge clk);
    obs_q.push_back({frame_start, pix_valid, pix_x, pix_y, pix_rgb});
    if (err) err_cnt++;
    if (crc_valid) begin
      crcv_cnt++;
      crc_last = frame_crc;
    end
    if (locked && !lock_prev) lock_rise_at = step_n;
    lock_prev = locked;
    rst = rs;
    hs = h;
    vs = v;
    {r, g, b} = rgb;
    exp_q.push_back(e);
    step_n++;
  endtask

  // kind: 0 clean, 1 short line, 2 hs held 2100 clocks, 3 reset pulse
  task automatic run_frame(input int pat, input bit pix_en,
                           input int kind, input int cut_ln,
                           input int cut_hc);
    bit en = pix_en;
    for (int ln = 0; ln < VT; ln++) begin
      int len = (kind == 1 && ln == cut_ln) ? HT - 1 : HT;
      if (kind == 1 && ln == cut_ln + 1) en = 0;
      if (kind == 2 && ln == cut_ln) begin
        for (int k = 0; k < 2100; k++)
          step(1'b0, ~POL, ~POL, 9'($urandom), '0);
        return;
      end
      for (int hc = 0; hc < len; hc++) begin
        bit rs = (kind == 3 && ln == cut_ln && hc == cut_hc);
        int x = hc - HS;
        int y = ln - VS;
        logic [9:0] xv = 10'(x);
        logic [9:0] yv = 10'(y);
        logic [8:0] px;
        bit a;
        case (pat)
          1: px = {xv[2:0], yv[2:0], xv[5:3]};
          2: px = 9'h1ff;
          default: px = 9'($urandom);
        endcase
        if (rs) begin
          en = 0;
          exp_q[exp_q.size() - 1] = '0;
        end
        a = en && x >= 0 && x < HA && y >= 0 && y < VA;
        step(rs, (hc < HSW) ? POL : ~POL, (ln < VSW) ? POL : ~POL, px,
             a ? {(x == 0 && y == 0), 1'b1, xv, yv, px} : 31'h0);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, ~POL, ~POL, 9'h0, '0);
    checks += 9;
    if (pix_valid !== 1'b0) begin errors++; $display("FAIL rst_pix_valid got %b want 0", pix_valid); end
    if (pix_x !== 10'd0) begin errors++; $display("FAIL rst_pix_x got %0d want 0", pix_x); end
    if (pix_y !== 10'd0) begin errors++; $display("FAIL rst_pix_y got %0d want 0", pix_y); end
    if (pix_rgb !== 9'd0) begin errors++; $display("FAIL rst_pix_rgb got %h want 0", pix_rgb); end
    if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start got %b want 0", frame_start); end
    if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %b want 0", locked); end
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    if (frame_crc !== 16'h0) begin errors++; $display("FAIL rst_frame_crc got %h want 0", frame_crc); end
    if (crc_valid !== 1'b0) begin errors++; $display("FAIL rst_crc_valid got %b want 0", crc_valid); end
  endtask

  task automatic test_golden();
    int base = obs_q.size();
    int s2, nv = 0, nfs = 0;
    run_frame(0, 0, 0, 0, 0);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL gold_lock_f1 got %b want 0", locked); end
    s2 = step_n;
    run_frame(0, 0, 0, 0, 0);
    run_frame(0, 1, 0, 0, 0);
    checks++;
    if (lock_rise_at != s2 + 2) begin errors++; $display("FAIL gold_lock_rise got %0d want %0d", lock_rise_at, s2 + 2); end
    for (int i = base; i < obs_q.size(); i++) begin
      nv += int'(obs_q[i][29]);
      nfs += int'(obs_q[i][30]);
    end
    checks += 2;
    if (nv != HA * VA) begin errors++; $display("FAIL gold_pix_count got %0d want %0d", nv, HA * VA); end
    if (nfs != 1) begin errors++; $display("FAIL gold_frame_start got %0d want 1", nfs); end
    for (int i = chk_from; i + 2 < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i + 2] !== exp_q[i]) begin errors++; $display("FAIL gold_stream step %0d got %h want %h", i, obs_q[i + 2], exp_q[i]); end
    end
    chk_from = obs_q.size() - 2;
  endtask

  task automatic test_pattern();
    int base = obs_q.size();
    int nv = 0;
    run_frame(1, 1, 0, 0, 0);
    for (int i = base; i < obs_q.size(); i++) nv += int'(obs_q[i][29]);
    checks++;
    if (nv != HA * VA) begin errors++; $display("FAIL pat_pix_count got %0d want %0d", nv, HA * VA); end
    for (int i = chk_from; i + 2 < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i + 2] !== exp_q[i]) begin errors++; $display("FAIL pat_stream step %0d got %h want %h", i, obs_q[i + 2], exp_q[i]); end
    end
    chk_from = obs_q.size() - 2;
  endtask

  task automatic test_short_line();
    int e0 = err_cnt;
    int sc;
    run_frame(0, 1, 1, VS + 2, 0);
    checks += 2;
    if (err_cnt != e0 + 1) begin errors++; $display("FAIL short_err got %0d want %0d", err_cnt, e0 + 1); end
    if (locked !== 1'b0) begin errors++; $display("FAIL short_unlock got %b want 0", locked); end
    run_frame(0, 0, 0, 0, 0);
    sc = step_n;
    run_frame(0, 0, 0, 0, 0);
    run_frame(0, 1, 0, 0, 0);
    checks += 2;
    if (lock_rise_at != sc + 2) begin errors++; $display("FAIL short_relock got %0d want %0d", lock_rise_at, sc + 2); end
    if (err_cnt != e0 + 1) begin errors++; $display("FAIL short_err_total got %0d want %0d", err_cnt, e0 + 1); end
    for (int i = chk_from; i + 2 < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i + 2] !== exp_q[i]) begin errors++; $display("FAIL short_stream step %0d got %h want %h", i, obs_q[i + 2], exp_q[i]); end
    end
    chk_from = obs_q.size() - 2;
  endtask

  task automatic test_hold();
    int e0 = err_cnt;
    int sc;
    run_frame(0, 1, 2, VS + 4, 0);
    checks += 2;
    if (err_cnt != e0 + 1) begin errors++; $display("FAIL hold_err got %0d want %0d", err_cnt, e0 + 1); end
    if (locked !== 1'b0) begin errors++; $display("FAIL hold_unlock got %b want 0", locked); end
    run_frame(0, 0, 0, 0, 0);
    sc = step_n;
    run_frame(0, 0, 0, 0, 0);
    run_frame(0, 1, 0, 0, 0);
    checks++;
    if (lock_rise_at != sc + 2) begin errors++; $display("FAIL hold_relock got %0d want %0d", lock_rise_at, sc + 2); end
    for (int i = chk_from; i + 2 < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i + 2] !== exp_q[i]) begin errors++; $display("FAIL hold_stream step %0d got %h want %h", i, obs_q[i + 2], exp_q[i]); end
    end
    chk_from = obs_q.size() - 2;
  endtask

  task automatic test_rst_mid();
    int e0 = err_cnt;
    int sc;
    run_frame(0, 1, 3, VS + 1, HS + 5);
    checks += 2;
    if (locked !== 1'b0) begin errors++; $display("FAIL rstmid_unlock got %b want 0", locked); end
    if (err_cnt != e0) begin errors++; $display("FAIL rstmid_err got %0d want %0d", err_cnt, e0); end
    run_frame(0, 0, 0, 0, 0);
    sc = step_n;
    run_frame(0, 0, 0, 0, 0);
    run_frame(0, 1, 0, 0, 0);
    checks++;
    if (lock_rise_at != sc + 2) begin errors++; $display("FAIL rstmid_relock got %0d want %0d", lock_rise_at, sc + 2); end
    for (int i = chk_from; i + 2 < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i + 2] !== exp_q[i]) begin errors++; $display("FAIL rstmid_stream step %0d got %h want %h", i, obs_q[i + 2], exp_q[i]); end
    end
    chk_from = obs_q.size() - 2;
  endtask

  task automatic test_crc();
    int c0 = crcv_cnt;
`ifdef VGA_RX_CRC_EN
    logic [15:0] c = 16'hffff;
    logic [8:0] d = 9'h1ff;
    for (int p = 0; p < HA * VA; p++)
      for (int bi = 8; bi >= 0; bi--)
        c = {c[14:0], 1'b0} ^ ((c[15] ^ d[bi]) ? 16'h1021 : 16'h0);
    run_frame(2, 1, 0, 0, 0);
    checks += 2;
    if (crcv_cnt != c0 + 1) begin errors++; $display("FAIL crc_pulse1 got %0d want %0d", crcv_cnt, c0 + 1); end
    if (crc_last !== c) begin errors++; $display("FAIL crc_value1 got %h want %h", crc_last, c); end
    run_frame(2, 1, 0, 0, 0);
    checks += 2;
    if (crcv_cnt != c0 + 2) begin errors++; $display("FAIL crc_pulse2 got %0d want %0d", crcv_cnt, c0 + 2); end
    if (crc_last !== c) begin errors++; $display("FAIL crc_value2 got %h want %h", crc_last, c); end
`else
    run_frame(2, 1, 0, 0, 0);
    run_frame(2, 1, 0, 0, 0);
    checks += 2;
    if (crcv_cnt != 0 || c0 != 0) begin errors++; $display("FAIL crc_off_pulse got %0d want 0", crcv_cnt); end
    if (frame_crc !== 16'h0) begin errors++; $display("FAIL crc_off_value got %h want 0", frame_crc); end
`endif
    for (int i = chk_from; i + 2 < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i + 2] !== exp_q[i]) begin errors++; $display("FAIL crc_stream step %0d got %h want %h", i, obs_q[i + 2], exp_q[i]); end
    end
    chk_from = obs_q.size() - 2;
  endtask

  initial begin
    test_reset();
    test_golden();
    test_pattern();
    test_short_line();
    test_hold();
    test_rst_mid();
    test_crc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
